iter_div: RTL and testbench

Multi-cycle radix-2 restoring integer divider. It is the responder side of the divide handshake issued by the EX stage. EX pulses `div` for one cycle with the operands, then stalls on `complete`. The block returns quotient `s` and remainder `r` after a fixed latency. It replaces the single-reset-input divider with an explicit `cancel` input, so pipeline flushes no longer need to be folded into reset.

---
 rtl/iter_div.sv | 167 ++++++++++++++++
 tb/tb_iter_div.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div.sv
// iter_div: multi-cycle radix-2 restoring integer divider.
// Accepts a start pulse with operands, computes one quotient bit per cycle
// on operand magnitudes, then registers sign-corrected quotient/remainder.
// An explicit cancel input aborts an operation without resetting results.
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div,
  input  logic             cancel,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             complete,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Step counter and datapath registers
  logic [CW-1:0]    counter_reg;
  logic [WIDTH:0]   rem_reg;     // partial remainder, one guard bit
  logic [WIDTH-1:0] dvd_reg;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] mag_y_reg;
  logic             sx_reg;
  logic             sy_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] r_reg;

  // Combinational helpers
  logic             start;
  logic             last_step;
  logic             finish;
  logic             sx_in;
  logic             sy_in;
  logic [WIDTH-1:0] mag_x_in;
  logic [WIDTH-1:0] mag_y_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             trial_neg;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] rem_low;

  // A start is only accepted in IDLE or DONE, and cancel always wins
  assign start     = div & ~cancel & ((state_reg == IDLE) | (state_reg == DONE));
  assign last_step = (counter_reg == CW'(WIDTH - 1));
  assign finish    = (state_reg == CALC) & last_step & ~cancel;

  // Operand signs and magnitudes; the most negative value maps onto itself,
  // which reads correctly as an unsigned magnitude
  assign sx_in    = div_signed & x[WIDTH-1];
  assign sy_in    = div_signed & y[WIDTH-1];
  assign mag_x_in = sx_in ? (~x + WIDTH'(1)) : x;
  assign mag_y_in = sy_in ? (~y + WIDTH'(1)) : y;

  // One restoring step: shift, trial-subtract, keep or restore.
  // The remainder stays below |y|, so the shifted value fits WIDTH+1 bits;
  // one extra bit in the difference carries the borrow.
  assign shifted   = {rem_reg[WIDTH-1:0], dvd_reg[WIDTH-1]};
  assign diff      = {1'b0, shifted} - {2'b00, mag_y_reg};
  assign trial_neg = diff[WIDTH+1];
  assign rem_step  = trial_neg ? shifted : diff[WIDTH:0];
  assign q_step    = {dvd_reg[WIDTH-2:0], ~trial_neg};
  assign rem_low   = rem_step[WIDTH-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: cancel has priority over both completion and restart
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (div && !cancel) state_next = CALC;
      end
      CALC: begin
        if (cancel)         state_next = IDLE;
        else if (last_step) state_next = DONE;
      end
      DONE: begin
        if (cancel)   state_next = IDLE;
        else if (div) state_next = CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    complete = 1'b0;
    busy     = 1'b0;
    case (state_reg)
      CALC:    busy     = 1'b1;
      DONE:    complete = 1'b1;
      default: begin
        complete = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Step counter: cleared on start, advances once per CALC cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter_reg <= '0;
    end else if (start) begin
      counter_reg <= '0;
    end else if (state_reg == CALC) begin
      counter_reg <= counter_reg + CW'(1);
    end
  end

  // Iteration datapath: load magnitudes on start, one step per CALC cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_reg   <= '0;
      dvd_reg   <= '0;
      mag_y_reg <= '0;
      sx_reg    <= 1'b0;
      sy_reg    <= 1'b0;
    end else if (start) begin
      rem_reg   <= '0;
      dvd_reg   <= mag_x_in;
      mag_y_reg <= mag_y_in;
      sx_reg    <= sx_in;
      sy_reg    <= sy_in;
    end else if (state_reg == CALC) begin
      rem_reg <= rem_step;
      dvd_reg <= q_step;
    end
  end

  // Result registers: written only on the edge that enters DONE, so they
  // hold through later calculations, cancels and idle periods
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_reg <= '0;
      r_reg <= '0;
    end else if (finish) begin
      s_reg <= (sx_reg ^ sy_reg) ? (~q_step + WIDTH'(1)) : q_step;
      r_reg <= sx_reg ? (~rem_low + WIDTH'(1)) : rem_low;
    end
  end

  assign s = s_reg;
  assign r = r_reg;

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed scoreboard bench for iter_div.
// Stimulus pushes expected {s, r, completion cycle}; a negedge monitor pops
// and compares on each rising edge of complete.
module tb_iter_div;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div = 1'b0;
  logic        cancel = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [31:0] s;
  logic [31:0] r;
  logic        complete;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] s;
    logic [31:0] r;
    int          at;
  } exp_t;

  exp_t sb[$];
  logic complete_prev = 1'b0;

  iter_div #(.WIDTH(32)) dut (
    .clk(clk),
    .resetn(resetn),
    .div(div),
    .cancel(cancel),
    .div_signed(div_signed),
    .x(x),
    .y(y),
    .s(s),
    .r(r),
    .complete(complete),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard
  always @(negedge clk) begin
    if (complete && !complete_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_complete", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_s", s, e.s);
        chk("result_r", r, e.r);
        chk("result_cycle", 32'(cyc), 32'(e.at));
        $display("result at cycle %0d: s=0x%08h r=0x%08h", cyc, s, r);
      end
    end
    complete_prev = complete;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start; expect_it=0 for operations that must never complete
  task automatic issue(input logic sg, input logic [31:0] xa, input logic [31:0] ya,
                       input logic expect_it, input logic [31:0] es, input logic [31:0] er);
    exp_t e;
    div = 1'b1;
    div_signed = sg;
    x = xa;
    y = ya;
    if (expect_it) begin
      e.s = es;
      e.r = er;
      e.at = cyc + 33;
      sb.push_back(e);
    end
    $display("issue cycle %0d: signed=%0b x=0x%08h y=0x%08h", cyc, sg, xa, ya);
    step();
    div = 1'b0;
    x = $urandom;
    y = $urandom;
    div_signed = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) until complete; returns at the negedge of the first DONE cycle
  task automatic wait_complete(output int nbusy);
    logic seen;
    seen = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (complete) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("complete_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int nb;

    // Reset state
    resetn = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_s", s, 32'h0);
    chk("reset_r", r, 32'h0);
    chk("reset_complete", 32'(complete), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    step();
    resetn = 1'b1;
    step();

    // Unsigned 100/7, busy exactly 32 cycles
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);
    wait_complete(nb);
    chk("busy_len", 32'(nb), 32'd32);

    // Signed and corner vectors, each started in the first DONE cycle
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("b2b_complete_drop", 32'(complete), 32'd0);
    wait_complete(nb);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    wait_complete(nb);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    wait_complete(nb);
    issue(1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5);
    wait_complete(nb);
    issue(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'd1, 32'hFFFF_FFFB);
    wait_complete(nb);
    issue(1'b1, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd9);
    wait_complete(nb);
    step();

    // Cancel in cycle 10 of CALC, restart in cycle 12
    issue(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0);   // now cycle 1 of CALC
    repeat (9) step();                                   // cycle 10
    cancel = 1'b1;
    step();                                              // cycle 11
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_complete", 32'(complete), 32'd0);
    chk("cancel_hold_s", s, 32'hFFFF_FFFF);
    chk("cancel_hold_r", r, 32'd9);
    step();                                              // cycle 12
    issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0);
    wait_complete(nb);
    step();

    // Cancel alone from DONE, then div+cancel together in IDLE
    cancel = 1'b1;
    step();
    cancel = 1'b1;
    div = 1'b1;
    x = 32'd50;
    y = 32'd5;
    @(negedge clk);
    chk("done_cancel_complete", 32'(complete), 32'd0);
    step();
    div = 1'b0;
    cancel = 1'b0;
    @(negedge clk);
    chk("div_cancel_nostart_busy", 32'(busy), 32'd0);
    chk("idle_hold_s", s, 32'd3);
    step();

    // Div during CALC is ignored
    issue(1'b0, 32'd1000, 32'd10, 1'b1, 32'd100, 32'd0);
    repeat (4) step();
    div = 1'b1;
    x = 32'd1;
    y = 32'd1;
    step();
    div = 1'b0;
    wait_complete(nb);

    // Back-to-back from first DONE cycle
    issue(1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0FFF_FFFF, 32'hF);
    @(negedge clk);
    chk("b2b2_complete_drop", 32'(complete), 32'd0);
    wait_complete(nb);
    step();

    // Reset in cycle 20 of CALC
    issue(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0);
    repeat (19) step();
    resetn = 1'b0;
    step();
    @(negedge clk);
    chk("midreset_s", s, 32'h0);
    chk("midreset_r", r, 32'h0);
    chk("midreset_complete", 32'(complete), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    step();
    resetn = 1'b1;
    repeat (40) step();

    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
